// File: rtl/control_sequencer.sv
// control_sequencer: instruction sequencer; ISSUE one cycle after accept, memory ops then WAIT until mem_ack.
// in_ready only in IDLE (at most one instruction per 2 cycles); WAIT watchdog built only with CTRL_TIMEOUT_EN.
module control_sequencer #(
  parameter int OPW      = 6,
  parameter int REGW     = 3,
  parameter int IMMW     = 8,
  parameter int IM_AW    = 16,
  parameter int IM_DEPTH = 65536,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OPW-1:0]    alu_ctrl,
  output logic [REGW-1:0]   rd,
  output logic [REGW-1:0]   r1,
  output logic [REGW-1:0]   r2,
  output logic [IMMW-1:0]   i1,
  output logic [IMMW-1:0]   i2,
  output logic              rwe,
  output logic              rwe2,
  output logic              mem_req,
  output logic              dm_we,
  output logic              dm_re,
  output logic              im_re,
  output logic              im_wd,
  input  logic              mem_ack,
  output logic [IM_AW-1:0]  im_raddr,
  output logic [IM_AW-1:0]  im_waddr,
  output logic              frame_done,
  output logic              ill_op,
  output logic              timeout_err
);

  localparam int IW = 32;
  localparam logic [IM_AW-1:0] IM_LAST = IM_AW'(IM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q;
  logic           accept;
  logic           is_alu, is_mov, is_strdm, is_ldrdm, is_strim, is_ldrim, is_br, is_mem;
  logic           ack_ok;
  logic           unused_pad;

  assign accept     = (state == IDLE) && in_valid;
  assign ack_ok     = (state == WAIT) && mem_ack;
  assign unused_pad = ^instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      rd   <= '0;
      r1   <= '0;
      r2   <= '0;
      i1   <= '0;
      i2   <= '0;
    end else if (accept) begin
      op_q <= instr[IW-1 -: OPW];
      rd   <= instr[IW-1-OPW -: REGW];
      r1   <= instr[IW-1-OPW-REGW -: REGW];
      r2   <= instr[IW-1-OPW-2*REGW -: REGW];
      i1   <= instr[2*IMMW-1 -: IMMW];
      i2   <= instr[IMMW-1:0];
    end
  end

  always_comb begin
    is_mov   = (op_q == OPW'(3));
    is_alu   = (op_q >= OPW'(1)) && (op_q <= OPW'(7)) && !is_mov;
    is_strdm = (op_q == OPW'(8));
    is_ldrdm = (op_q == OPW'(9));
    is_strim = (op_q == OPW'(10));
    is_ldrim = (op_q == OPW'(11));
    is_br    = (op_q >= OPW'(12)) && (op_q <= OPW'(24));
    is_mem   = is_strdm || is_ldrdm || is_strim || is_ldrim;
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] wait_cnt;
  logic           to_fire;
  logic           to_q;

  assign to_fire = (state == WAIT) && !mem_ack && (wait_cnt == TCW'(TIMEOUT - 1));

  // Counter is held at zero outside WAIT, so it is clear on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + TCW'(1) : '0;
      to_q     <= to_fire;
    end
  end
  assign timeout_err = to_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = (state == IDLE);
    alu_ctrl   = '0;
    rwe        = 1'b0;
    rwe2       = 1'b0;
    mem_req    = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    im_re      = 1'b0;
    im_wd      = 1'b0;
    frame_done = 1'b0;
    ill_op     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = is_mem ? WAIT : IDLE;
        alu_ctrl  = (is_alu || is_br) ? op_q : '0;
        rwe       = is_alu;
        rwe2      = is_mov;
        ill_op    = !(is_alu || is_mov || is_mem || is_br);
      end
      WAIT: begin
        mem_req = 1'b1;
        dm_we   = is_strdm;
        dm_re   = is_ldrdm;
        im_re   = is_ldrim;
        im_wd   = is_strim;
        if (mem_ack) begin
          state_nxt  = IDLE;
          rwe        = is_ldrdm;
          frame_done = is_strim && (im_waddr == IM_LAST);
        end
`ifdef CTRL_TIMEOUT_EN
        else if (to_fire) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_raddr <= '0;
      im_waddr <= '0;
    end else if (ack_ok) begin
      if (is_ldrim) im_raddr <= (im_raddr == IM_LAST) ? '0 : im_raddr + IM_AW'(1);
      if (is_strim) im_waddr <= (im_waddr == IM_LAST) ? '0 : im_waddr + IM_AW'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (IM_DEPTH=4, TIMEOUT=5): opcode table plus memory/reset/watchdog sequences.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid, in_ready;
  logic [5:0]  alu_ctrl;
  logic [2:0]  rd, r1, r2;
  logic [7:0]  i1, i2;
  logic        rwe, rwe2, mem_req, dm_we, dm_re, im_re, im_wd, mem_ack;
  logic [15:0] im_raddr, im_waddr;
  logic        frame_done, ill_op, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .OPW(6), .REGW(3), .IMMW(8), .IM_AW(16), .IM_DEPTH(4), .TIMEOUT(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .rd(rd), .r1(r1), .r2(r2), .i1(i1), .i2(i2),
    .rwe(rwe), .rwe2(rwe2), .mem_req(mem_req), .dm_we(dm_we), .dm_re(dm_re),
    .im_re(im_re), .im_wd(im_wd), .mem_ack(mem_ack), .im_raddr(im_raddr),
    .im_waddr(im_waddr), .frame_done(frame_done), .ill_op(ill_op),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [5:0] op;
    logic [2:0] rd, r1, r2;
    logic [7:0] i1, i2;
    logic [5:0] e_alu;
    logic       e_rwe, e_rwe2, e_ill;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] d, input logic [2:0] a,
                                     input logic [2:0] b, input logic [7:0] x, input logic [7:0] y);
    return {op, d, a, b, 1'b0, x, y};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge in IDLE; returns just after the edge entering ISSUE.
  task automatic accept_instr(input logic [31:0] w);
    instr    = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    instr    = 32'hFFFF_FFFF;
  endtask

  task automatic quiet(input string nm);
    chk({nm, "_rwe"}, 32'(rwe), 0);
    chk({nm, "_rwe2"}, 32'(rwe2), 0);
    chk({nm, "_mem_req"}, 32'(mem_req), 0);
    chk({nm, "_ill"}, 32'(ill_op), 0);
  endtask

  initial begin
    tv[0]  = '{6'd1,  3'd2, 3'd0, 3'd1, 8'h11, 8'h22, 6'd1,  1'b1, 1'b0, 1'b0};
    tv[1]  = '{6'd2,  3'd7, 3'd6, 3'd5, 8'hA5, 8'h5A, 6'd2,  1'b1, 1'b0, 1'b0};
    tv[2]  = '{6'd3,  3'd4, 3'd0, 3'd0, 8'h00, 8'h5A, 6'd0,  1'b0, 1'b1, 1'b0};
    tv[3]  = '{6'd4,  3'd1, 3'd2, 3'd3, 8'h01, 8'h02, 6'd4,  1'b1, 1'b0, 1'b0};
    tv[4]  = '{6'd6,  3'd3, 3'd3, 3'd3, 8'hFF, 8'h00, 6'd6,  1'b1, 1'b0, 1'b0};
    tv[5]  = '{6'd7,  3'd5, 3'd1, 3'd4, 8'h80, 8'h7F, 6'd7,  1'b1, 1'b0, 1'b0};
    tv[6]  = '{6'd12, 3'd0, 3'd1, 3'd2, 8'h10, 8'h20, 6'd12, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{6'd24, 3'd6, 3'd7, 3'd0, 8'h33, 8'h44, 6'd24, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{6'd0,  3'd1, 3'd1, 3'd1, 8'h01, 8'h01, 6'd0,  1'b0, 1'b0, 1'b1};
    tv[9]  = '{6'd25, 3'd2, 3'd2, 3'd2, 8'h02, 8'h02, 6'd0,  1'b0, 1'b0, 1'b1};
    tv[10] = '{6'h3F, 3'd3, 3'd4, 3'd5, 8'hC3, 8'h3C, 6'd0,  1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; instr = '0; in_valid = 1'b0; mem_ack = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu", 32'(alu_ctrl), 0);
    chk("rst_fields", {rd, r1, r2, i1, i2}, 0);
    chk("rst_ptrs", {im_raddr, im_waddr}, 0);
    chk("rst_pulses", {29'd0, frame_done, ill_op, timeout_err}, 0);
    quiet("rst");
    rst_n = 1'b1;
    step();

    // Opcode table: ISSUE cycle contents, then return to IDLE.
    for (int v = 0; v < 11; v++) begin
      accept_instr(mk(tv[v].op, tv[v].rd, tv[v].r1, tv[v].r2, tv[v].i1, tv[v].i2));
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 0);
      chk($sformatf("v%0d_alu", v), 32'(alu_ctrl), 32'(tv[v].e_alu));
      chk($sformatf("v%0d_strobes", v), {29'd0, rwe, rwe2, ill_op},
          {29'd0, tv[v].e_rwe, tv[v].e_rwe2, tv[v].e_ill});
      chk($sformatf("v%0d_mem_req", v), 32'(mem_req), 0);
      chk($sformatf("v%0d_fields", v), {rd, r1, r2, i1, i2},
          {tv[v].rd, tv[v].r1, tv[v].r2, tv[v].i1, tv[v].i2});
      step();
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), 32'(in_ready), 1);
      chk($sformatf("v%0d_idle_alu", v), 32'(alu_ctrl), 0);
      quiet($sformatf("v%0d_idle", v));
      chk($sformatf("v%0d_hold", v), {rd, r1, r2, i1, i2},
          {tv[v].rd, tv[v].r1, tv[v].r2, tv[v].i1, tv[v].i2});
      step();
    end

    // LDR_DM with ack in the third WAIT cycle.
    accept_instr(mk(6'd9, 3'd5, 3'd1, 3'd0, 8'h04, 8'h00));
    @(negedge clk);
    chk("ldr_issue_mem_req", 32'(mem_req), 0);
    chk("ldr_issue_rwe", 32'(rwe), 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) mem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("ldr_w%0d_req", c), {30'd0, mem_req, dm_re}, 3);
      chk($sformatf("ldr_w%0d_rwe", c), 32'(rwe), (c == 3) ? 1 : 0);
      chk($sformatf("ldr_w%0d_in_ready", c), 32'(in_ready), 0);
    end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("ldr_done_in_ready", 32'(in_ready), 1);
    chk("ldr_done_req", {30'd0, mem_req, dm_re}, 0);
    chk("ldr_done_rwe", 32'(rwe), 0);

    // Ack while IDLE must not move pointers.
    step();
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("stray_ack_ptrs", {im_raddr, im_waddr}, 0);

    // Five STR_IM with immediate ack; depth 4 wraps on the fourth.
    for (int j = 0; j < 5; j++) begin
      accept_instr(mk(6'd10, 3'd0, 3'd2, 3'd0, 8'h00, 8'h00));
      step();
      mem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("sim%0d_im_wd", j), {30'd0, mem_req, im_wd}, 3);
      chk($sformatf("sim%0d_frame_done", j), 32'(frame_done), (j == 3) ? 1 : 0);
      step();
      mem_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("sim%0d_waddr", j), 32'(im_waddr), 32'((j + 1) % 4));
      chk($sformatf("sim%0d_fd_low", j), 32'(frame_done), 0);
      chk($sformatf("sim%0d_raddr", j), 32'(im_raddr), 0);
      step();
    end

    // LDR_IM acked once, then a second aborted by reset mid-WAIT.
    accept_instr(mk(6'd11, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00));
    step();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("lim_im_re", {30'd0, mem_req, im_re}, 3);
    step();
    mem_ack = 1'b0;
    chk("lim_raddr", 32'(im_raddr), 1);
    step();
    accept_instr(mk(6'd11, 3'd6, 3'd0, 3'd0, 8'h00, 8'h00));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req", {30'd0, mem_req, im_re}, 0);
    chk("rst_wait_in_ready", 32'(in_ready), 1);
    chk("rst_wait_ptrs", {im_raddr, im_waddr}, 0);
    chk("rst_wait_fields", {rd, r1, r2, i1, i2}, 0);
    mem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("post_rst_ack_raddr", 32'(im_raddr), 0);
    chk("post_rst_ack_req", 32'(mem_req), 0);

`ifdef CTRL_TIMEOUT_EN
    // STR_DM never acked: 5 WAIT cycles, then timeout_err in the first IDLE cycle.
    accept_instr(mk(6'd8, 3'd0, 3'd1, 3'd2, 8'h00, 8'h00));
    for (int c = 1; c <= 5; c++) begin
      step();
      @(negedge clk);
      chk($sformatf("to_w%0d_req", c), {30'd0, mem_req, dm_we}, 3);
      chk($sformatf("to_w%0d_err", c), 32'(timeout_err), 0);
    end
    step();
    @(negedge clk);
    chk("to_err_pulse", 32'(timeout_err), 1);
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_in_ready", 32'(in_ready), 1);
    chk("to_rwe", 32'(rwe), 0);
    step();
    @(negedge clk);
    chk("to_err_single", 32'(timeout_err), 0);
    chk("to_ptrs", {im_raddr, im_waddr}, 0);
`else
    // Without the watchdog, WAIT outlasts TIMEOUT until acked.
    accept_instr(mk(6'd8, 3'd0, 3'd1, 3'd2, 8'h00, 8'h00));
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 7) mem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("nto_w%0d_req", c), {30'd0, mem_req, dm_we}, 3);
      chk($sformatf("nto_w%0d_err", c), 32'(timeout_err), 0);
    end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("nto_done_in_ready", 32'(in_ready), 1);
    chk("nto_done_req", 32'(mem_req), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised, clocked successor to the combinational instruction decoder: accepts one instruction per valid/ready handshake, registers the decoded fields, and issues register-file, ALU and memory strobes for a fixed number of cycles. Memory-class instructions (data memory and image memory) stall the sequencer until the memory acknowledges. Raw-image read and processed-image write pointers advance on those acknowledgements. Sits between instruction fetch and the datapath (register file, ALU, data memory, image memories).

## Interface
Parameters:
- OPW, 6: opcode width.
- REGW, 3: register index width.
- IMMW, 8: width of each immediate.
- IM_AW, 16: image address pointer width.
- IM_DEPTH, 65536: pixels per frame; pointers wrap at IM_DEPTH-1. Must be ≤ 2^IM_AW.
- TIMEOUT, 255: WAIT-state watchdog limit in cycles (used only with CTRL_TIMEOUT_EN).

Instruction layout, MSB first:
- opcode (OPW), rd (REGW), r1 (REGW), r2 (REGW), zero pad, i1 (IMMW), i2 (IMMW).
- Total width is 32.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word.
- in_valid  in  1  instruction is present.
- in_ready  out  1  sequencer can accept.
- alu_ctrl  out  OPW  ALU operation code.
- rd, r1, r2  out  REGW  register indices.
- i1, i2  out  IMMW  immediates.
- rwe  out  1  register write enable (ALU result or loaded data).
- rwe2  out  1  register write of i2 (MOV).
- mem_req  out  1  memory request active.
- dm_we  out  1  data memory write qualifier.
- dm_re  out  1  data memory read qualifier.
- im_re  out  1  raw-image read qualifier.
- im_wd  out  1  processed-image write qualifier.
- mem_ack  in  1  memory completes the request.
- im_raddr  out  IM_AW  raw-image read pointer.
- im_waddr  out  IM_AW  processed-image write pointer.
- frame_done  out  1  one-cycle pulse when im_waddr wraps.
- ill_op  out  1  one-cycle pulse for an undefined opcode.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
Opcode map:
- Op 1–7: ALU ops. 1 ADD, 2 SUB, 4 DIV, 5 MUL, 6 AND, 7 OR. Set alu_ctrl = opcode and rwe.
- Op 3: MOV. Sets rwe2; alu_ctrl = 0.
- Op 8: STR_DM. Sets dm_we.
- Op 9: LDR_DM. Sets dm_re.
- Op 10: STR_IM. Sets im_wd.
- Op 11: LDR_IM. Sets im_re.
- Op 12–24: branch compares. alu_ctrl = opcode; no write.
- Any other opcode, including 0: pulses ill_op and writes nothing.

FSM states IDLE, ISSUE, WAIT:
- IDLE: in_ready = 1. When in_valid is high, latch all fields and go to ISSUE.
- ISSUE: for non-memory ops, alu_ctrl and rwe/rwe2 are valid for exactly this cycle, then go to IDLE. For memory ops, go to WAIT with no rwe.
- WAIT: mem_req = 1, with the op's qualifier held high.
  - On mem_ack: drop mem_req and the qualifier, go to IDLE.
  - LDR_DM asserts rwe in the ack cycle.
  - LDR_IM increments im_raddr; STR_IM increments im_waddr.

General rules:
- Field outputs (rd, r1, r2, i1, i2) hold their latched values until the next accept.
- Strobe outputs are 0 outside the states listed above.
- A pointer at IM_DEPTH-1 wraps to 0. A wrap of im_waddr pulses frame_done in the same cycle as the ack.
- mem_ack outside WAIT is ignored.
- Reset at any time, including mid-WAIT, forces IDLE immediately and aborts the request without advancing pointers.

## Timing
- Reset values:
  - in_ready = 1.
  - All other outputs 0, including im_raddr, im_waddr, the field registers, and every pulse output.
- Accept happens at edge N. ISSUE is cycle N+1; the next accept is possible at edge N+2.
- Non-memory throughput: one instruction per 2 cycles.
- Memory ops: WAIT starts at cycle N+2. Total latency is 2 + k cycles, where k ≥ 1 is the number of WAIT cycles up to and including the ack cycle.
- All outputs are registered or decoded only from state and latched fields, never directly from instr.

## Configuration
- CTRL_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - At TIMEOUT cycles without mem_ack: pulse timeout_err, drop mem_req, return to IDLE. No rwe, no pointer change.
- Undefined: no counter is built, timeout_err is tied to 0, and WAIT lasts until mem_ack.

## Test plan
- Reset, then ADD (op 1, rd=2, r1=0, r2=1) → in_ready low for 1 cycle; alu_ctrl=1 and rwe=1 in cycle N+1 only.
- LDR_DM with mem_ack delayed 3 cycles → mem_req and dm_re high for 3 cycles; rwe=1 only in the ack cycle; in_ready returns on the next cycle.
- IM_DEPTH=4, five STR_IM ops with immediate ack → im_waddr goes 1,2,3,0,1; frame_done pulses exactly once, on the 4th ack.
- Opcode 0x3F → ill_op pulses one cycle; rwe, rwe2 and mem_req stay 0; the sequencer is back in IDLE.
- LDR_IM, rst_n low during WAIT → all outputs 0 and im_raddr = 0 immediately; a later mem_ack is ignored.
- With CTRL_TIMEOUT_EN and TIMEOUT=5, STR_DM never acked → timeout_err pulses after 5 WAIT cycles, then the sequencer returns to IDLE with pointers unchanged.
